// File: rtl/generic_fifo_pkg.sv
// rtl/generic_fifo_pkg.sv - shared types and constants for the generic FIFO read side
package generic_fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } drain_state_e;

   // Words the output skid can hold; also the cap on popped-but-undelivered words
   localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/generic_fifo_skid_buf.sv
// rtl/generic_fifo_skid_buf.sv - two-entry skid buffer with push/pop/clear, head drives the stream
module generic_fifo_skid_buf
   import generic_fifo_pkg::*;
#(
   parameter int DAT_WIDTH = 35
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 push,
   input  logic [DAT_WIDTH-1:0] push_data,
   input  logic                 pop,
   output logic [1:0]           buf_cnt,
   output logic                 head_valid,
   output logic [DAT_WIDTH-1:0] head_data
);

   localparam logic [1:0] FULL_CNT = 2'(SKID_DEPTH);

   logic [DAT_WIDTH-1:0] ent0_q, ent0_d;
   logic [DAT_WIDTH-1:0] ent1_q, ent1_d;
   logic [1:0]           cnt_q, cnt_d;
   logic                 pop_ok;
   logic [1:0]           cnt_after_pop;

   // Shift on pop, then write the incoming word into the first free slot
   always_comb begin
      pop_ok        = pop & (cnt_q != 2'd0);
      cnt_after_pop = cnt_q - {1'b0, pop_ok};
      ent0_d        = ent0_q;
      ent1_d        = ent1_q;
      if (pop_ok) begin
         ent0_d = ent1_q;
      end
      if (push && (cnt_after_pop == 2'd0)) begin
         ent0_d = push_data;
      end
      if (push && (cnt_after_pop == 2'd1)) begin
         ent1_d = push_data;
      end
      cnt_d = cnt_after_pop + {1'b0, push};
      if (clear) begin
         cnt_d = 2'd0;
      end
   end

   // Buffer storage and fill count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign buf_cnt    = cnt_q;
   assign head_valid = (cnt_q != 2'd0);
   assign head_data  = ent0_q;

   // A write into a full skid means the pop-ahead limit in the drain was broken
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && !clear && (cnt_q == FULL_CNT)));

endmodule

// File: rtl/generic_fifo_rd_drain.sv
// rtl/generic_fifo_rd_drain.sv - FIFO read-side drain engine feeding a valid/ready stream
module generic_fifo_rd_drain
   import generic_fifo_pkg::*;
#(
   parameter int DAT_WIDTH = 35,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 rd_clk,
   input  logic                 rd_reset,
   input  logic                 enable,
   input  logic                 flush,
   input  logic                 rd_empty,
   input  logic                 rd_empty_err,
   output logic                 rd_op,
   input  logic [DAT_WIDTH-1:0] rd_data,
   output logic                 out_valid,
   output logic [DAT_WIDTH-1:0] out_data,
   input  logic                 out_ready,
   output logic [CNT_WIDTH-1:0] words_cnt,
   output logic                 busy,
   output logic                 err
);

   drain_state_e         state_q, state_d;
   logic                 inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0] words_cnt_q, words_cnt_d;
   logic                 err_q, err_d;
   logic [1:0]           buf_cnt;
   logic                 pop;
   logic                 push;
   logic                 buf_clear;
   logic [2:0]           occ_after_pop;

   generic_fifo_skid_buf #(
      .DAT_WIDTH (DAT_WIDTH)
   ) u_skid (
      .clk        (rd_clk),
      .rst        (rd_reset),
      .clear      (buf_clear),
      .push       (push),
      .push_data  (rd_data),
      .pop        (pop),
      .buf_cnt    (buf_cnt),
      .head_valid (out_valid),
      .head_data  (out_data)
   );

   // Stream handshake, buffer write/clear, and occupancy after this cycle's pop
   always_comb begin
      pop           = out_valid & out_ready;
      buf_clear     = flush | (state_q == ST_FLUSH);
      push          = inflight_q & ~buf_clear;
      occ_after_pop = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
   end

   // State register
   always_ff @(posedge rd_clk or posedge rd_reset) begin
      if (rd_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: flush wins; RUN/FLUSH leave only once the returning read has landed
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_FLUSH;
      end else begin
         case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable && !inflight_q) state_d = ST_IDLE;
            ST_FLUSH: if (rd_empty && !inflight_q) state_d = enable ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs: pop-ahead only while the skid can still absorb the returning word
   always_comb begin
      rd_op = 1'b0;
      case (state_q)
         ST_RUN:   rd_op = enable & ~rd_empty & (occ_after_pop < 3'(SKID_DEPTH));
         ST_FLUSH: rd_op = ~rd_empty;
         default:  rd_op = 1'b0;
      endcase
      busy = (state_q != ST_IDLE) | inflight_q | (buf_cnt != 2'd0);
   end

   // Read-latency tracker, saturating delivery counter and sticky error
   always_comb begin
      inflight_d  = rd_op;
      words_cnt_d = words_cnt_q;
      if (pop && (words_cnt_q != {CNT_WIDTH{1'b1}})) begin
         words_cnt_d = words_cnt_q + CNT_WIDTH'(1);
      end
      err_d = err_q | rd_empty_err | (rd_op & rd_empty);
   end

   // Datapath registers
   always_ff @(posedge rd_clk or posedge rd_reset) begin
      if (rd_reset) begin
         inflight_q  <= 1'b0;
         words_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         inflight_q  <= inflight_d;
         words_cnt_q <= words_cnt_d;
         err_q       <= err_d;
      end
   end

   assign words_cnt = words_cnt_q;
   assign err       = err_q;

endmodule

// File: tb/tb_generic_fifo_rd_drain.sv
// tb/tb_generic_fifo_rd_drain.sv - self-checking bench for generic_fifo_rd_drain
module tb_generic_fifo_rd_drain;

   localparam int DW = 35;
   localparam int CW = 16;

   typedef struct packed {
      logic          start;
      logic          ready;
      logic          e_rd_op;
      logic          e_valid;
      logic [DW-1:0] e_data;
   } vec_t;

   logic          rd_clk = 1'b0;
   logic          rd_reset;
   logic          enable, flush, rd_empty, rd_empty_err, rd_op;
   logic [DW-1:0] rd_data, out_data;
   logic          out_valid, out_ready, busy, err;
   logic [CW-1:0] words_cnt;

   logic          en2, flush2, rd_empty2, rd_empty_err2, rd_op2, out_valid2, out_ready2, busy2, err2;
   logic [DW-1:0] rd_data2, out_data2;
   logic [3:0]    words_cnt2;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int            popped, delivered, rdop_cnt;
   bit            chk_stream;
   bit            p_have, p_valid, p_ready;
   logic [DW-1:0] p_data;

   always #5 rd_clk = ~rd_clk;

   generic_fifo_rd_drain #(.DAT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .rd_clk(rd_clk), .rd_reset(rd_reset), .enable(enable), .flush(flush),
      .rd_empty(rd_empty), .rd_empty_err(rd_empty_err), .rd_op(rd_op), .rd_data(rd_data),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .words_cnt(words_cnt), .busy(busy), .err(err)
   );

   generic_fifo_rd_drain #(.DAT_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
      .rd_clk(rd_clk), .rd_reset(rd_reset), .enable(en2), .flush(flush2),
      .rd_empty(rd_empty2), .rd_empty_err(rd_empty_err2), .rd_op(rd_op2), .rd_data(rd_data2),
      .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
      .words_cnt(words_cnt2), .busy(busy2), .err(err2)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic do_reset();
      rd_reset = 1'b1;
      enable = 0; flush = 0; out_ready = 0; rd_empty_err = 0; en2 = 0;
      fifo_q.delete(); exp_q.delete();
      rd_empty = 1'b1; rd_data = '0;
      popped = 0; delivered = 0; rdop_cnt = 0; p_have = 0; chk_stream = 0;
      repeat (2) @(posedge rd_clk);
      #1 rd_reset = 1'b0;
   endtask

   task automatic preload(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
      rd_empty = (fifo_q.size() == 0);
   endtask

   // One clock: sample mid-cycle, then play the FIFO (one-cycle read latency) after the edge
   task automatic tick();
      logic          s_rd_op, s_valid, s_ready, s_empty;
      logic [DW-1:0] s_data;
      #1;
      s_rd_op = rd_op; s_valid = out_valid; s_ready = out_ready; s_data = out_data; s_empty = rd_empty;
      if (chk_stream) begin
         if (s_rd_op) check("rd_op_while_empty", 64'(s_empty), 64'd0);
         if (p_have && p_valid && !p_ready) begin
            check("hold_valid", 64'(s_valid), 64'd1);
            check("hold_data", 64'(s_data), 64'(p_data));
         end
         if (s_valid && s_ready) begin
            if (exp_q.size() == 0) check("unexpected_word", 64'(s_data), 64'hdead);
            else check("stream_data", 64'(s_data), 64'(exp_q.pop_front()));
         end
      end
      if (s_valid && s_ready) delivered++;
      if (s_rd_op) rdop_cnt++;
      p_have = 1; p_valid = s_valid; p_ready = s_ready; p_data = s_data;
      @(posedge rd_clk);
      #1;
      if (s_rd_op && fifo_q.size() > 0) begin
         rd_data = fifo_q.pop_front();
         exp_q.push_back(rd_data);
         popped++;
      end
      rd_empty = (fifo_q.size() == 0);
      if (chk_stream) check("outstanding_le_2", 64'((popped - delivered) <= 2), 64'd1);
   endtask

   initial begin
      vec_t vecs[$];
      int   injected, d2, bound;
      bit   v2, vseen;
      logic [CW-1:0] cnt0;

      // Preload 1..4, ready high: pops in cycles 0-3, words from cycle 2
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 35'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 35'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 35'h0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 35'h1});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 35'h2});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 35'h3});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 35'h4});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 35'h0});
      // Preload 1..4, ready low: exactly two pops, word 1 held, then release
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 35'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 35'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 35'h0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 35'h1});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 35'h1});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 35'h1});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 35'h1});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 35'h2});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 35'h3});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 35'h4});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 35'h0});

      flush2 = 0; rd_empty2 = 0; rd_empty_err2 = 0; out_ready2 = 1; rd_data2 = 35'h5a5;
      do_reset();

      // Reset state
      #1;
      check("rst_rd_op", 64'(rd_op), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_words_cnt", 64'(words_cnt), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);

      // Table-driven latency and backpressure sequences
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].start) begin
            if (i != 0) check("table_words_cnt", 64'(words_cnt), 64'd4);
            do_reset();
            preload(4, 35'h1);
            enable = 1'b1;
            chk_stream = 1;
         end
         out_ready = vecs[i].ready;
         #1;
         check("tbl_rd_op", 64'(rd_op), 64'(vecs[i].e_rd_op));
         check("tbl_out_valid", 64'(out_valid), 64'(vecs[i].e_valid));
         if (vecs[i].e_valid) check("tbl_out_data", 64'(out_data), 64'(vecs[i].e_data));
         tick();
      end
      check("table_words_cnt", 64'(words_cnt), 64'd4);

      // Eight words with ready toggling
      do_reset();
      preload(8, 35'h100);
      enable = 1'b1;
      chk_stream = 1;
      for (int i = 0; i < 40; i++) begin
         out_ready = (i % 2 == 0);
         tick();
      end
      check("toggle_words_cnt", 64'(words_cnt), 64'd8);
      check("toggle_all_delivered", 64'(exp_q.size()), 64'd0);

      // Random ready and random FIFO refills against the scoreboard
      do_reset();
      enable = 1'b1;
      chk_stream = 1;
      injected = 0;
      for (int i = 0; i < 600; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) begin
            int n;
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) fifo_q.push_back(DW'($urandom));
            injected += n;
            rd_empty = 1'b0;
         end
         tick();
      end
      out_ready = 1'b1;
      bound = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || out_valid) && bound < 50) begin
         tick();
         bound++;
      end
      check("rand_drain_in_time", 64'(bound < 50), 64'd1);
      check("rand_words_cnt", 64'(words_cnt), 64'(injected));

      // Flush with a full buffer and five words waiting
      do_reset();
      preload(2, 35'h11);
      enable = 1'b1;
      repeat (4) tick();
      preload(5, 35'h21);
      cnt0 = words_cnt;
      #1;
      check("pre_flush_valid", 64'(out_valid), 64'd1);
      flush = 1'b1;
      rdop_cnt = 0;
      tick();
      flush = 1'b0;
      #1;
      check("flush_clears_valid", 64'(out_valid), 64'd0);
      vseen = 0;
      for (int i = 0; i < 20 && fifo_q.size() != 0; i++) begin
         tick();
         if (out_valid) vseen = 1;
      end
      check("flush_fifo_drained", 64'(fifo_q.size()), 64'd0);
      repeat (3) begin
         tick();
         if (out_valid) vseen = 1;
      end
      check("flush_rd_op_count", 64'(rdop_cnt), 64'd5);
      check("flush_no_valid", 64'(vseen), 64'd0);
      check("flush_words_cnt", 64'(words_cnt), 64'(cnt0));
      exp_q.delete(); popped = 0; delivered = 0; p_have = 0;
      preload(1, 35'h99);
      out_ready = 1'b1;
      chk_stream = 1;
      #1;
      check("flush_back_to_run", 64'(rd_op), 64'd1);
      repeat (4) tick();
      check("post_flush_words_cnt", 64'(words_cnt), 64'(cnt0) + 64'd1);

      // Flush coinciding with a pop: the pop counts, buffer is still cleared
      do_reset();
      preload(2, 35'h31);
      enable = 1'b1;
      repeat (4) tick();
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b0;
      #1;
      check("flush_pop_counts", 64'(words_cnt), 64'd1);
      check("flush_pop_valid", 64'(out_valid), 64'd0);
      repeat (3) tick();
      check("flush_pop_stays_empty", 64'(out_valid), 64'd0);

      // Sticky error
      check("err_before", 64'(err), 64'd0);
      rd_empty_err = 1'b1;
      tick();
      rd_empty_err = 1'b0;
      check("err_set", 64'(err), 64'd1);
      repeat (5) tick();
      check("err_sticky", 64'(err), 64'd1);

      // Asynchronous reset in the middle of a stream
      exp_q.delete();
      preload(6, 35'h200);
      out_ready = 1'b1;
      repeat (4) tick();
      check("pre_reset_valid", 64'(out_valid), 64'd1);
      #2 rd_reset = 1'b1;
      #1;
      check("mid_rst_rd_op", 64'(rd_op), 64'd0);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_out_data", 64'(out_data), 64'd0);
      check("mid_rst_words_cnt", 64'(words_cnt), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_err", 64'(err), 64'd0);
      do_reset();

      // Saturating counter on the 4-bit instance
      en2 = 1'b1;
      d2 = 0;
      for (int i = 0; i < 30; i++) begin
         #1;
         v2 = out_valid2;
         @(posedge rd_clk);
         #1;
         if (v2) d2++;
         check("sat_cnt", 64'(words_cnt2), 64'((d2 > 15) ? 15 : d2));
      end
      check("sat_enough_words", 64'(d2 >= 20), 64'd1);
      check("sat_final", 64'(words_cnt2), 64'd15);
      en2 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/generic_fifo_rd_drain.md
# generic_fifo_rd_drain

Read-side drain engine for the generic dual-clock FIFO. Lives in the FIFO read-clock domain, issues pops against the FIFO control (rd_op/rd_empty), absorbs the one-cycle read latency of the 1r1w compiled RAM, and presents words on a valid/ready stream through a 2-entry skid buffer. It also provides flush, a delivered-word counter and a sticky underflow flag.

## Interface
- DAT_WIDTH, 35, FIFO word width
- CNT_WIDTH, 16, delivered-word counter width
- rd_clk  in  1  read-domain clock, all logic rising-edge
- rd_reset  in  1  asynchronous, active-high reset
- enable  in  1  level; allows pops in RUN
- flush  in  1  single-cycle pulse; discard buffer and drain FIFO
- rd_empty  in  1  FIFO empty (read domain)
- rd_empty_err  in  1  FIFO read-while-empty error
- rd_op  out  1  pop request; RAM read enable
- rd_data  in  DAT_WIDTH  RAM read data, valid the cycle after rd_op
- out_valid  out  1  stream valid
- out_data  out  DAT_WIDTH  stream data
- out_ready  in  1  stream ready
- words_cnt  out  CNT_WIDTH  delivered words, saturating
- busy  out  1  state != IDLE, or in-flight/buffer nonzero
- err  out  1  sticky: rd_empty_err seen, or rd_op issued with rd_empty high

## Operation
- State machine: IDLE, RUN, FLUSH. Reset -> IDLE.
- IDLE -> RUN when enable=1. RUN -> IDLE when enable=0, once in-flight=0 (the buffer keeps presenting in IDLE). Any state -> FLUSH on flush=1 (flush beats enable).
- FLUSH: buffer cleared, out_valid forced 0, returned words dropped. Pops continue each cycle while rd_empty=0. Exits when rd_empty=1 and in-flight=0: to RUN if enable else IDLE.
- Occupancy occ = buf_cnt + inflight (0..2). pop = out_valid & out_ready.
- RUN: rd_op = !rd_empty & (occ - pop < 2). FLUSH: rd_op = !rd_empty. IDLE: rd_op = 0.
- inflight register = rd_op of the previous cycle. When it is 1, rd_data is written into the buffer tail (dropped in FLUSH, or when flush is asserted in that same cycle).
- Buffer: 2 entries, head drives out_data. Push and pop in the same cycle are both honoured. Skid guarantees no overflow: push with buf_cnt=2 is impossible by construction and is checked by assertion.
- words_cnt += 1 on each pop, saturates at all-ones, cleared only by reset.
- err sets on rd_empty_err=1, or on rd_op=1 with rd_empty=1. Cleared only by reset.

## Timing
- Reset values: rd_op=0, out_valid=0, out_data=0, words_cnt=0, busy=0, err=0, buf_cnt=0, inflight=0.
- rd_op is combinational from registers, rd_empty and out_ready. No other output is combinational.
- Latency: rd_op in cycle N, rd_data sampled at the end of N+1, out_valid high in N+2.
- Throughput: 1 word/cycle sustained while out_ready=1 and rd_empty=0.
- out_valid/out_data stay stable until pop. out_valid never drops without pop, except on flush.
- rd_empty must fall no earlier than the cycle after the last pop of a word. This matches the FIFO's registered pointers.
- Flush in the same cycle as a pop: the pop counts (words_cnt increments) and the buffer is cleared.
- Reset mid-stream: all state cleared immediately. In-flight data is lost.

## Structure
- Shared package generic_fifo_pkg holds the state encoding typedef (IDLE/RUN/FLUSH) and SKID_DEPTH=2.
- One sub-module: generic_fifo_skid_buf (2-entry buffer with push/pop/clear, buf_cnt, head out).
- Top holds the FSM, rd_op logic, inflight flag, counter and err.

## Test plan
- Preload 4 words (0x1..0x4), enable=1, out_ready=1 -> rd_op in cycles 0-3, out_valid from cycle 2, data 1,2,3,4 in consecutive cycles, words_cnt=4.
- Preload 8 words, out_ready toggling 1/0 -> no loss or duplication, at most 2 unreturned pops outstanding, order preserved, words_cnt=8.
- out_ready=0 with FIFO non-empty -> exactly 2 rd_op pulses, then rd_op=0. out_data holds word 1 until ready.
- Buffer full (2 words) plus 5 words in FIFO, pulse flush -> out_valid=0 next cycle, 5 more rd_op, returns to RUN after empty, words_cnt unchanged.
- Pulse rd_empty_err=1 -> err=1 and stays 1. Assert rd_reset mid-stream -> all outputs at reset values in the same cycle.
- CNT_WIDTH=4, deliver 20 words -> words_cnt saturates at 15.
